// File: rtl/hyperbus_trans_sched_pkg.sv
// Purpose: shared types and chunk-size helper for the HyperBus transaction scheduler.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package hyperbus_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_e;

    // Beat count of a transaction or chunk: 1..256 needs 9 bits.
    typedef logic [8:0] beats_t;

    // Beats in the next chunk. Only the low address bits matter because the
    // boundary is at most 256 beats = 512 bytes. Wrapping bursts are never split.
    function automatic beats_t chunk_beats(
        input logic [8:0]  addr_lo,
        input beats_t      remaining,
        input logic        incr,
        input int unsigned max_burst
    );
        int unsigned off;
        int unsigned room;
        off  = (32'(addr_lo) >> 1) & (max_burst - 1);
        room = max_burst - off;
        if (incr && (32'(remaining) > room)) begin
            return beats_t'(room);
        end
        return remaining;
    endfunction

endpackage

// File: rtl/hyperbus_trans_sched_if.sv
// Purpose: upstream request, PHY chunk request, rx/b handshake taps and status of the scheduler.
// Latency: n/a (signal bundle only).
// Backpressure: up_valid/up_ready and phy_valid/phy_ready are valid-ready pairs.
// Ports: slave = scheduler side, master = front-end / PHY / observer side.
interface hyperbus_trans_sched_if #(
    parameter int unsigned AddrWidth  = 32,
    parameter int unsigned NumChipSel = 2
);
    // upstream request
    logic                  up_valid;
    logic                  up_ready;
    logic [AddrWidth-1:0]  up_addr;
    logic [NumChipSel-1:0] up_cs;
    logic                  up_write;
    logic [7:0]            up_len;
    logic                  up_burst_type;
    logic                  up_addr_space;
    // PHY chunk request
    logic                  phy_valid;
    logic                  phy_ready;
    logic [AddrWidth-1:0]  phy_addr;
    logic [NumChipSel-1:0] phy_cs;
    logic                  phy_write;
    logic [7:0]            phy_len;
    logic                  phy_burst_type;
    logic                  phy_addr_space;
    // read-beat and write-response taps
    logic                  rx_valid;
    logic                  rx_ready;
    logic                  rx_last;
    logic                  b_valid;
    logic                  b_ready;
    logic                  b_last;
    // status
    logic                  busy;
    logic                  done;
    logic                  done_err;
    logic                  timeout;

    modport slave (
        input  up_valid, up_addr, up_cs, up_write, up_len, up_burst_type, up_addr_space,
        output up_ready,
        output phy_valid, phy_addr, phy_cs, phy_write, phy_len, phy_burst_type, phy_addr_space,
        input  phy_ready,
        input  rx_valid, rx_ready, rx_last, b_valid, b_ready, b_last,
        output busy, done, done_err, timeout
    );

    modport master (
        output up_valid, up_addr, up_cs, up_write, up_len, up_burst_type, up_addr_space,
        input  up_ready,
        input  phy_valid, phy_addr, phy_cs, phy_write, phy_len, phy_burst_type, phy_addr_space,
        output phy_ready,
        output rx_valid, rx_ready, rx_last, b_valid, b_ready, b_last,
        input  busy, done, done_err, timeout
    );

endinterface

// File: rtl/hyperbus_trans_sched.sv
// Purpose: splits one upstream transaction into MaxBurst-aligned PHY chunks, one outstanding at a time.
// Latency: first chunk valid the cycle after acceptance; done one cycle after the final last beat.
// Backpressure: up_ready only in IDLE outside the done cycle; phy_* held stable until phy_ready.
// Ports: clk_i, rst_i (async, active high), bus (slave modport: up_*, phy_*, rx/b taps, status).
module hyperbus_trans_sched
    import hyperbus_sched_pkg::*;
#(
    parameter int unsigned AddrWidth     = 32,
    parameter int unsigned NumChipSel    = 2,
    parameter int unsigned MaxBurst      = 16,   // power of two, 2..256
    parameter int unsigned TimeoutCycles = 1024  // >= 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    hyperbus_trans_sched_if.slave  bus
);

    localparam int unsigned TmoW = $clog2(TimeoutCycles);
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TimeoutCycles - 1);

    state_e                 state_q;
    logic                   phy_valid_q;
    logic [AddrWidth-1:0]   phy_addr_q;
    logic [NumChipSel-1:0]  phy_cs_q;
    logic                   phy_write_q;
    logic [7:0]             phy_len_q;
    logic                   phy_burst_q;
    logic                   phy_space_q;
    beats_t                 remaining_q;   // beats still owed, including the chunk in flight
    beats_t                 beats_q;       // beats of the chunk in flight
    logic [TmoW-1:0]        tmo_cnt_q;
    logic                   done_q;
    logic                   done_err_q;
    logic                   timeout_q;

    beats_t                 up_total;
    beats_t                 first_beats;
    beats_t                 next_rem;
    beats_t                 next_beats;
    logic [AddrWidth-1:0]   next_addr;
    logic                   beat_hs;
    logic                   chunk_end;
    logic                   accept;

    always_comb begin
        up_total    = beats_t'(bus.up_len) + beats_t'(1);
        first_beats = chunk_beats(bus.up_addr[8:0], up_total, bus.up_burst_type, MaxBurst);
        // Next chunk starts right after the one in flight (16-bit beats = 2 bytes).
        next_addr   = phy_addr_q + AddrWidth'({beats_q, 1'b0});
        next_rem    = remaining_q - beats_q;
        next_beats  = chunk_beats(next_addr[8:0], next_rem, phy_burst_q, MaxBurst);
        // Only the handshake channel matching the chunk direction counts.
        beat_hs     = phy_write_q ? (bus.b_valid && bus.b_ready)
                                  : (bus.rx_valid && bus.rx_ready);
        chunk_end   = beat_hs && (phy_write_q ? bus.b_last : bus.rx_last);
        accept      = bus.up_valid && bus.up_ready;
    end

    // Holding ready low during the done pulse forces one IDLE cycle between transactions.
    assign bus.up_ready       = (state_q == IDLE) && !done_q;
    assign bus.phy_valid      = phy_valid_q;
    assign bus.phy_addr       = phy_addr_q;
    assign bus.phy_cs         = phy_cs_q;
    assign bus.phy_write      = phy_write_q;
    assign bus.phy_len        = phy_len_q;
    assign bus.phy_burst_type = phy_burst_q;
    assign bus.phy_addr_space = phy_space_q;
    assign bus.busy           = (state_q != IDLE);
    assign bus.done           = done_q;
    assign bus.done_err       = done_err_q;
    assign bus.timeout        = timeout_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            phy_valid_q <= 1'b0;
            phy_addr_q  <= '0;
            phy_cs_q    <= '0;
            phy_write_q <= 1'b0;
            phy_len_q   <= '0;
            phy_burst_q <= 1'b0;
            phy_space_q <= 1'b0;
            remaining_q <= '0;
            beats_q     <= '0;
            tmo_cnt_q   <= '0;
            done_q      <= 1'b0;
            done_err_q  <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            done_err_q <= 1'b0;
            timeout_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        phy_addr_q  <= bus.up_addr;
                        phy_cs_q    <= bus.up_cs;
                        phy_write_q <= bus.up_write;
                        phy_burst_q <= bus.up_burst_type;
                        phy_space_q <= bus.up_addr_space;
                        remaining_q <= up_total;
                        beats_q     <= first_beats;
                        phy_len_q   <= 8'(first_beats - beats_t'(1));
                        phy_valid_q <= 1'b1;
                        state_q     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (bus.phy_ready) begin
                        phy_valid_q <= 1'b0;
                        tmo_cnt_q   <= '0;
                        state_q     <= WAIT;
                    end
                end
                WAIT: begin
                    if (chunk_end) begin
                        // Completion beats a coincident timeout.
                        if (next_rem != '0) begin
                            phy_addr_q  <= next_addr;
                            remaining_q <= next_rem;
                            beats_q     <= next_beats;
                            phy_len_q   <= 8'(next_beats - beats_t'(1));
                            phy_valid_q <= 1'b1;
                            state_q     <= ISSUE;
                        end else begin
                            remaining_q <= '0;
                            done_q      <= 1'b1;
                            state_q     <= IDLE;
                        end
                    end else if (beat_hs) begin
                        tmo_cnt_q <= '0;
                    end else if (tmo_cnt_q == TmoLast) begin
                        // Abort decided in the last allowed WAIT cycle; pulses show next cycle in IDLE.
                        remaining_q <= '0;
                        done_q      <= 1'b1;
                        done_err_q  <= 1'b1;
                        timeout_q   <= 1'b1;
                        state_q     <= IDLE;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + TmoW'(1);
                    end
                end
                default: begin
                    phy_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hyperbus_trans_sched.sv
module tb_hyperbus_trans_sched;

    localparam int unsigned AW  = 32;
    localparam int unsigned NCS = 2;
    localparam int unsigned MB  = 16;
    localparam int unsigned TMO = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    hyperbus_trans_sched_if #(.AddrWidth(AW), .NumChipSel(NCS)) bus ();

    hyperbus_trans_sched #(
        .AddrWidth(AW), .NumChipSel(NCS), .MaxBurst(MB), .TimeoutCycles(TMO)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Expected chunk list of the transaction under test.
    logic [31:0] exp_addr[$];
    logic [7:0]  exp_len[$];

    // Reference split: walk the byte address, cutting at every 2*MB-byte aligned boundary.
    task automatic build_chunks(input logic [31:0] addr, input logic [7:0] len, input logic incr);
        longint unsigned a, rem, bnd, room, beats;
        exp_addr.delete();
        exp_len.delete();
        a   = addr;
        rem = longint'(len) + 1;
        while (rem > 0) begin
            if (incr) begin
                bnd   = (a / (2 * MB) + 1) * (2 * MB);
                room  = (bnd - a) / 2;
                beats = (rem < room) ? rem : room;
            end else begin
                beats = rem;
            end
            exp_addr.push_back(a[31:0]);
            exp_len.push_back(8'(beats - 1));
            a   = (a + 2 * beats) % (64'd1 << 32);
            rem = rem - beats;
        end
    endtask

    task automatic idle_inputs();
        bus.up_valid = 0; bus.up_addr = '0; bus.up_cs = '0; bus.up_write = 0;
        bus.up_len = '0; bus.up_burst_type = 0; bus.up_addr_space = 0;
        bus.phy_ready = 0;
        bus.rx_valid = 0; bus.rx_ready = 0; bus.rx_last = 0;
        bus.b_valid = 0; bus.b_ready = 0; bus.b_last = 0;
    endtask

    // One beat/response handshake after 'gap' cycles of noise that must not complete the chunk.
    task automatic beat(input logic wr, input logic last, input int gap);
        int noise;
        for (int g = 0; g < gap; g++) begin
            noise = int'($urandom_range(0, 2));
            {bus.rx_valid, bus.rx_ready, bus.rx_last} = 3'b000;
            {bus.b_valid, bus.b_ready, bus.b_last} = 3'b000;
            if (noise == 1) begin
                if (wr) {bus.rx_valid, bus.rx_ready, bus.rx_last} = 3'b111;
                else    {bus.b_valid, bus.b_ready, bus.b_last} = 3'b111;
            end else if (noise == 2) begin
                if (wr) {bus.b_valid, bus.b_last} = 2'b11;
                else    {bus.rx_valid, bus.rx_last} = 2'b11;
            end
            @(negedge clk);
            checks++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b1) begin
                errors++;
                $display("FAIL gap_noise: done=%0b busy=%0b required done=0 busy=1", bus.done, bus.busy);
            end
        end
        {bus.rx_valid, bus.rx_ready, bus.rx_last} = 3'b000;
        {bus.b_valid, bus.b_ready, bus.b_last} = 3'b000;
        if (wr) {bus.b_valid, bus.b_ready, bus.b_last} = {2'b11, last};
        else    {bus.rx_valid, bus.rx_ready, bus.rx_last} = {2'b11, last};
        @(negedge clk);
        {bus.rx_valid, bus.rx_ready, bus.rx_last} = 3'b000;
        {bus.b_valid, bus.b_ready, bus.b_last} = 3'b000;
    endtask

    // Full transaction; stall<0 picks a random phy_ready delay per chunk. Returns at the done cycle.
    task automatic run_txn(input logic [31:0] addr, input logic [7:0] len, input logic wr,
                           input logic incr, input logic space, input logic [NCS-1:0] cs,
                           input int stall, input int max_gap, output int acc_wait);
        int s;
        build_chunks(addr, len, incr);
        bus.up_valid = 1; bus.up_addr = addr; bus.up_len = len; bus.up_write = wr;
        bus.up_burst_type = incr; bus.up_addr_space = space; bus.up_cs = cs;
        acc_wait = 0;
        while (bus.up_ready !== 1'b1 && acc_wait < 20) begin
            @(negedge clk);
            acc_wait++;
        end
        checks++;
        if (bus.up_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept: up_ready=%0b required 1 within 20 cycles", bus.up_ready);
            bus.up_valid = 0;
            return;
        end
        @(negedge clk);
        bus.up_valid = 0; bus.up_addr = $urandom; bus.up_len = 8'($urandom);
        bus.up_cs = '0; bus.up_write = ~wr; bus.up_burst_type = ~incr; bus.up_addr_space = ~space;
        for (int c = 0; c < exp_addr.size(); c++) begin
            s = (stall < 0) ? int'($urandom_range(0, 3)) : stall;
            for (int k = 0; k <= s; k++) begin
                if (k > 0) @(negedge clk);
                checks++;
                if (bus.phy_valid !== 1'b1 || bus.phy_addr !== exp_addr[c] || bus.phy_len !== exp_len[c] ||
                    bus.phy_write !== wr || bus.phy_cs !== cs || bus.phy_burst_type !== incr ||
                    bus.phy_addr_space !== space || bus.busy !== 1'b1) begin
                    errors++;
                    $display("FAIL chunk%0d_cyc%0d: vld=%0b addr=%h len=%0d w=%0b cs=%b bt=%0b as=%0b busy=%0b required vld=1 addr=%h len=%0d w=%0b cs=%b bt=%0b as=%0b busy=1",
                             c, k, bus.phy_valid, bus.phy_addr, bus.phy_len, bus.phy_write, bus.phy_cs,
                             bus.phy_burst_type, bus.phy_addr_space, bus.busy,
                             exp_addr[c], exp_len[c], wr, cs, incr, space);
                end
            end
            bus.phy_ready = 1;
            @(negedge clk);
            bus.phy_ready = 0;
            checks++;
            if (bus.phy_valid !== 1'b0) begin
                errors++;
                $display("FAIL phy_valid_drop%0d: phy_valid=%0b required 0", c, bus.phy_valid);
            end
            if (wr) begin
                beat(1'b1, 1'b1, int'($urandom_range(0, max_gap)));
            end else begin
                for (int i = 0; i <= int'(exp_len[c]); i++)
                    beat(1'b0, (i == int'(exp_len[c])), int'($urandom_range(0, max_gap)));
            end
            checks++;
            if (c == exp_addr.size() - 1) begin
                if (bus.done !== 1'b1 || bus.done_err !== 1'b0 || bus.timeout !== 1'b0 ||
                    bus.busy !== 1'b0 || bus.up_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL done: done=%0b err=%0b tmo=%0b busy=%0b up_ready=%0b required 1 0 0 0 0",
                             bus.done, bus.done_err, bus.timeout, bus.busy, bus.up_ready);
                end
            end else if (bus.done !== 1'b0) begin
                errors++;
                $display("FAIL early_done%0d: done=%0b required 0", c, bus.done);
            end
        end
    endtask

    task automatic check_idle(input string name);
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0 || bus.up_ready !== 1'b1 || bus.phy_valid !== 1'b0 ||
            bus.busy !== 1'b0 || bus.timeout !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle: done=%0b up_ready=%0b phy_valid=%0b busy=%0b tmo=%0b required 0 1 0 0 0",
                     name, bus.done, bus.up_ready, bus.phy_valid, bus.busy, bus.timeout);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (bus.phy_valid !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.done_err !== 1'b0 ||
            bus.timeout !== 1'b0 || bus.phy_addr !== '0 || bus.phy_len !== '0 || bus.phy_cs !== '0) begin
            errors++;
            $display("FAIL reset_outputs: vld=%0b busy=%0b done=%0b err=%0b tmo=%0b addr=%h len=%0d cs=%b required all 0",
                     bus.phy_valid, bus.busy, bus.done, bus.done_err, bus.timeout, bus.phy_addr, bus.phy_len, bus.phy_cs);
        end
        rst = 0;
        check_idle("reset_release");
    endtask

    task automatic test_read_single();
        int w;
        run_txn(32'h0000_0000, 8'd7, 1'b0, 1'b1, 1'b0, 2'b01, 0, 0, w);
        checks++;
        if (w != 0) begin
            errors++;
            $display("FAIL read_single_accept_wait: cycles=%0d required 0", w);
        end
        check_idle("read_single");
    endtask

    task automatic test_write_split();
        int w;
        run_txn(32'h0000_001C, 8'd9, 1'b1, 1'b1, 1'b1, 2'b10, 1, 2, w);
        check_idle("write_split");
    endtask

    task automatic test_wrap();
        int w;
        run_txn(32'h0000_0010, 8'd31, 1'b0, 1'b0, 1'b0, 2'b01, 0, 1, w);
        check_idle("wrap");
    endtask

    task automatic test_ready_stall();
        int w;
        run_txn(32'h0000_0040, 8'd3, 1'b0, 1'b1, 1'b1, 2'b10, 5, 0, w);
        check_idle("ready_stall");
    endtask

    task automatic test_timeout();
        int bad;
        int n;
        bus.up_valid = 1; bus.up_addr = 32'h0; bus.up_len = 8'd3; bus.up_write = 0;
        bus.up_burst_type = 1; bus.up_addr_space = 0; bus.up_cs = 2'b01;
        n = 0;
        while (bus.up_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        bus.up_valid = 0;
        bus.phy_ready = 1;
        @(negedge clk);
        bus.phy_ready = 0;
        bad = 0;
        for (int k = 0; k < int'(TMO); k++) begin
            if (bus.timeout !== 1'b0 || bus.done !== 1'b0 || bus.busy !== 1'b1) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL timeout_early: bad_wait_cycles=%0d required 0", bad);
        end
        checks++;
        if (bus.timeout !== 1'b1 || bus.done !== 1'b1 || bus.done_err !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_pulse: tmo=%0b done=%0b err=%0b busy=%0b required 1 1 1 0",
                     bus.timeout, bus.done, bus.done_err, bus.busy);
        end
        check_idle("timeout");
    endtask

    task automatic test_back_to_back();
        int w;
        run_txn(32'h0000_0100, 8'd20, 1'b0, 1'b1, 1'b0, 2'b01, -1, 2, w);
        run_txn(32'h0000_0236, 8'd5, 1'b1, 1'b1, 1'b1, 2'b10, -1, 2, w);
        checks++;
        if (w != 1) begin
            errors++;
            $display("FAIL back_to_back_accept: wait_cycles=%0d required 1", w);
        end
        check_idle("back_to_back");
    endtask

    task automatic test_reset_mid();
        int w;
        // reset while a chunk request is pending
        bus.up_valid = 1; bus.up_addr = 32'h1C; bus.up_len = 8'd9; bus.up_write = 1;
        bus.up_burst_type = 1; bus.up_addr_space = 0; bus.up_cs = 2'b01;
        @(negedge clk);
        bus.up_valid = 0;
        rst = 1;
        #1;
        checks++;
        if (bus.phy_valid !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL reset_issue: vld=%0b busy=%0b done=%0b required 0 0 0", bus.phy_valid, bus.busy, bus.done);
        end
        @(negedge clk);
        rst = 0;
        check_idle("reset_issue");
        // reset while waiting for chunk 1 to complete
        bus.up_valid = 1;
        @(negedge clk);
        bus.up_valid = 0;
        bus.phy_ready = 1;
        @(negedge clk);
        bus.phy_ready = 0;
        rst = 1;
        #1;
        checks++;
        if (bus.phy_valid !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.timeout !== 1'b0 ||
            bus.phy_addr !== '0 || bus.phy_len !== '0) begin
            errors++;
            $display("FAIL reset_wait: vld=%0b busy=%0b done=%0b tmo=%0b addr=%h len=%0d required all 0",
                     bus.phy_valid, bus.busy, bus.done, bus.timeout, bus.phy_addr, bus.phy_len);
        end
        @(negedge clk);
        rst = 0;
        for (int k = 0; k < 3; k++) check_idle("reset_wait");
        run_txn(32'h0000_001C, 8'd9, 1'b1, 1'b1, 1'b0, 2'b01, 0, 1, w);
        check_idle("reset_recover");
    endtask

    task automatic test_random();
        int w;
        logic [31:0] a;
        logic [7:0]  l;
        logic [NCS-1:0] cs;
        for (int t = 0; t < 25; t++) begin
            a  = $urandom;
            if ($urandom_range(0, 3) == 0) a[31:8] = 24'hFF_FFFF;
            a[0] = 1'b0;
            l  = ($urandom_range(0, 7) == 0) ? 8'd255 : 8'($urandom_range(0, 40));
            cs = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
            run_txn(a, l, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
                    1'($urandom_range(0, 1)), cs, -1, 3, w);
            if ($urandom_range(0, 1) == 0) check_idle("random");
        end
        check_idle("random_end");
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_read_single();
        test_write_split();
        test_wrap();
        test_ready_stall();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5_000_000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
